// File: rtl/demux_chan_counter.sv
// Per-channel rising-edge event counter for the demux outputs.
// Counters saturate and set a sticky overflow bit. One channel is read or cleared at a time.
module demux_chan_counter #(
  parameter int unsigned NCH  = 4,
  parameter int unsigned SELW = 2,
  parameter int unsigned CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NCH-1:0]  dout_in,
  input  logic            en,
  input  logic [SELW-1:0] rd_sel,
  input  logic            rd_clr,
  output logic [CNTW-1:0] cnt_out,
  output logic [NCH-1:0]  ovf,
  output logic [NCH-1:0]  active,
  output logic            any_evt
);

  localparam logic [CNTW-1:0] CntMax = '1;

  typedef enum logic [0:0] {StPrime, StRun} state_e;

  state_e          state_q, state_d;
  logic [NCH-1:0]  dout_q;
  logic [NCH-1:0]  rise;
  logic [NCH-1:0]  counted;
  logic [CNTW-1:0] cnt_q [NCH];
  logic [CNTW-1:0] cnt_d [NCH];
  logic [NCH-1:0]  ovf_q, ovf_d;
  logic [CNTW-1:0] cnt_out_q, cnt_out_d;
  logic            any_evt_q, any_evt_d;
  logic            sel_valid;

  always_comb begin
    // PRIME only lasts for the first edge after reset.
    state_d   = StRun;
    sel_valid = (32'(rd_sel) < NCH);
    rise      = '0;
    if (state_q == StRun) begin
      rise = dout_in & ~dout_q;
    end
    counted   = rise & {NCH{en}};
    any_evt_d = |counted;
    // Read path sees counts from before this edge's update.
    cnt_out_d = sel_valid ? cnt_q[rd_sel] : '0;

    for (int i = 0; i < NCH; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (counted[i]) begin
        if (cnt_q[i] == CntMax) begin
          ovf_d[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
      // A clear colliding with a counted rise keeps that rise.
      if (rd_clr && sel_valid && (int'(rd_sel) == i)) begin
        cnt_d[i] = CNTW'(counted[i]);
        ovf_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StPrime;
      dout_q    <= '0;
      ovf_q     <= '0;
      cnt_out_q <= '0;
      any_evt_q <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      dout_q    <= dout_in;
      ovf_q     <= ovf_d;
      cnt_out_q <= cnt_out_d;
      any_evt_q <= any_evt_d;
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign cnt_out = cnt_out_q;
  assign ovf     = ovf_q;
  assign active  = dout_q;
  assign any_evt = any_evt_q;

endmodule

// File: tb/tb_demux_chan_counter.sv
// Bench for demux_chan_counter: vector table, directed corner sequences and
// randomized traffic, all checked against a count-per-channel reference model.
module tb_demux_chan_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dout_in;
  logic       en;
  logic [1:0] rd_sel;
  logic       rd_clr;
  logic [7:0] cnt_out;
  logic [3:0] ovf;
  logic [3:0] active;
  logic       any_evt;

  int checks = 0;
  int errors = 0;

  demux_chan_counter #(.NCH(4), .SELW(2), .CNTW(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .dout_in (dout_in),
    .en      (en),
    .rd_sel  (rd_sel),
    .rd_clr  (rd_clr),
    .cnt_out (cnt_out),
    .ovf     (ovf),
    .active  (active),
    .any_evt (any_evt)
  );

  always #5 clk = ~clk;

  // Reference model: event totals per channel, the previous bus value and
  // whether the first post-reset edge has happened yet.
  int         m_cnt [4];
  logic [3:0] m_ovf;
  logic [3:0] m_act;
  logic       m_run;
  logic       m_evt;
  int         m_out;

  function automatic void model(input bit r, input bit [3:0] d, input bit e,
                                input bit [1:0] s, input bit c);
    if (r) begin
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
      m_ovf = '0;
      m_act = '0;
      m_run = 1'b0;
      m_evt = 1'b0;
      m_out = 0;
    end else begin
      m_out = m_cnt[s];
      m_evt = 1'b0;
      for (int i = 0; i < 4; i++) begin
        bit hit;
        hit = m_run && d[i] && !m_act[i] && e;
        if (hit) begin
          m_evt = 1'b1;
          if (m_cnt[i] == 255) m_ovf[i] = 1'b1;
          m_cnt[i] = (m_cnt[i] >= 255) ? 255 : m_cnt[i] + 1;
        end
        if (c && (s == i)) begin
          m_cnt[i] = hit ? 1 : 0;
          m_ovf[i] = 1'b0;
        end
      end
      m_act = d;
      m_run = 1'b1;
    end
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit [3:0] d, input bit e,
                      input bit [1:0] s, input bit c);
    rst     = r;
    dout_in = d;
    en      = e;
    rd_sel  = s;
    rd_clr  = c;
    @(posedge clk);
    model(r, d, e, s, c);
    #1;
    check("model cnt_out", int'(cnt_out), m_out);
    check("model ovf", int'(ovf), int'(m_ovf));
    check("model active", int'(active), int'(m_act));
    check("model any_evt", int'(any_evt), int'(m_evt));
  endtask

  task automatic pulse(input bit [3:0] m, input bit [1:0] s, input int n);
    repeat (n) begin
      step(1'b0, m, 1'b1, s, 1'b0);
      step(1'b0, 4'b0000, 1'b1, s, 1'b0);
    end
  endtask

  typedef struct {
    bit       r;
    bit [3:0] d;
    bit       e;
    bit [1:0] s;
    bit       c;
    int       x_cnt;
    bit [3:0] x_ovf;
    bit [3:0] x_act;
    bit       x_evt;
  } vec_t;

  vec_t vecs [10];

  initial begin
    // Reset held with all channels high, release, then first counted edges.
    vecs[0] = '{1'b1, 4'b1111, 1'b1, 2'd0, 1'b0, 0, 4'b0000, 4'b0000, 1'b0};
    vecs[1] = '{1'b1, 4'b1111, 1'b1, 2'd0, 1'b0, 0, 4'b0000, 4'b0000, 1'b0};
    vecs[2] = '{1'b1, 4'b1111, 1'b1, 2'd0, 1'b0, 0, 4'b0000, 4'b0000, 1'b0};
    vecs[3] = '{1'b0, 4'b1111, 1'b1, 2'd0, 1'b0, 0, 4'b0000, 4'b1111, 1'b0};
    vecs[4] = '{1'b0, 4'b1111, 1'b1, 2'd0, 1'b0, 0, 4'b0000, 4'b1111, 1'b0};
    vecs[5] = '{1'b0, 4'b0000, 1'b1, 2'd0, 1'b0, 0, 4'b0000, 4'b0000, 1'b0};
    vecs[6] = '{1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 0, 4'b0000, 4'b0001, 1'b1};
    vecs[7] = '{1'b0, 4'b0001, 1'b1, 2'd0, 1'b0, 1, 4'b0000, 4'b0001, 1'b0};
    vecs[8] = '{1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 0, 4'b0000, 4'b0010, 1'b1};
    vecs[9] = '{1'b0, 4'b0010, 1'b1, 2'd1, 1'b0, 1, 4'b0000, 4'b0010, 1'b0};

    for (int v = 0; v < 10; v++) begin
      step(vecs[v].r, vecs[v].d, vecs[v].e, vecs[v].s, vecs[v].c);
      check($sformatf("vec%0d cnt_out", v), int'(cnt_out), vecs[v].x_cnt);
      check($sformatf("vec%0d ovf", v), int'(ovf), int'(vecs[v].x_ovf));
      check($sformatf("vec%0d active", v), int'(active), int'(vecs[v].x_act));
      check($sformatf("vec%0d any_evt", v), int'(any_evt), int'(vecs[v].x_evt));
    end

    // Demux sweep: data routed to each channel in turn, then idle data.
    step(1'b1, 4'b0000, 1'b1, 2'd0, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      repeat (10) step(1'b0, 4'b0001 << c, 1'b1, 2'(c), 1'b0);
    end
    step(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 4'b0000, 1'b1, 2'(c), 1'b0);
      check($sformatf("sweep ch%0d", c), int'(cnt_out), 1);
    end
    repeat (40) step(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 4'b0000, 1'b1, 2'(c), 1'b0);
      check($sformatf("idle ch%0d", c), int'(cnt_out), 1);
    end

    // Saturation on ch2 with the boundary at 255 and 256 pulses.
    step(1'b1, 4'b0000, 1'b1, 2'd2, 1'b0);
    step(1'b0, 4'b0000, 1'b1, 2'd2, 1'b0);
    pulse(4'b0100, 2'd2, 255);
    check("sat 255 cnt", int'(cnt_out), 255);
    check("sat 255 ovf", int'(ovf), 0);
    pulse(4'b0100, 2'd2, 1);
    check("sat 256 cnt", int'(cnt_out), 255);
    check("sat 256 ovf", int'(ovf), 4'b0100);
    pulse(4'b0100, 2'd2, 44);
    check("sat 300 cnt", int'(cnt_out), 255);
    check("sat 300 ovf", int'(ovf), 4'b0100);

    // Clear colliding with a rise on ch1; other channels untouched.
    pulse(4'b0001, 2'd0, 2);
    pulse(4'b0010, 2'd1, 5);
    pulse(4'b1000, 2'd3, 1);
    step(1'b0, 4'b0010, 1'b1, 2'd1, 1'b1);
    step(1'b0, 4'b0000, 1'b1, 2'd0, 1'b0);
    check("clr ch0", int'(cnt_out), 2);
    step(1'b0, 4'b0000, 1'b1, 2'd1, 1'b0);
    check("clr ch1", int'(cnt_out), 1);
    step(1'b0, 4'b0000, 1'b1, 2'd2, 1'b0);
    check("clr ch2", int'(cnt_out), 255);
    step(1'b0, 4'b0000, 1'b1, 2'd3, 1'b0);
    check("clr ch3", int'(cnt_out), 1);
    check("clr ovf kept", int'(ovf), 4'b0100);
    step(1'b0, 4'b0100, 1'b1, 2'd2, 1'b1);
    step(1'b0, 4'b0000, 1'b1, 2'd2, 1'b0);
    check("clr sat ch2 cnt", int'(cnt_out), 1);
    check("clr sat ch2 ovf", int'(ovf), 0);
    step(1'b0, 4'b0000, 1'b1, 2'd3, 1'b1);
    step(1'b0, 4'b0000, 1'b1, 2'd3, 1'b0);
    check("plain clr ch3", int'(cnt_out), 0);

    // Enable gating on ch3.
    repeat (3) begin
      step(1'b0, 4'b1000, 1'b0, 2'd3, 1'b0);
      check("gated any_evt", int'(any_evt), 0);
      step(1'b0, 4'b0000, 1'b0, 2'd3, 1'b0);
    end
    check("gated cnt", int'(cnt_out), 0);
    step(1'b0, 4'b1000, 1'b1, 2'd3, 1'b0);
    check("enabled any_evt", int'(any_evt), 1);
    step(1'b0, 4'b0000, 1'b1, 2'd3, 1'b0);
    check("enabled any_evt drop", int'(any_evt), 0);
    check("enabled cnt", int'(cnt_out), 1);

    // Mid-run reset with ch3 held high through PRIME.
    step(1'b1, 4'b1000, 1'b1, 2'd3, 1'b0);
    check("midrst cnt_out", int'(cnt_out), 0);
    check("midrst ovf", int'(ovf), 0);
    check("midrst active", int'(active), 0);
    check("midrst any_evt", int'(any_evt), 0);
    repeat (4) step(1'b0, 4'b1000, 1'b1, 2'd3, 1'b0);
    check("prime held cnt", int'(cnt_out), 0);
    check("prime held evt", int'(any_evt), 0);
    check("prime held active", int'(active), 4'b1000);

    // Randomized traffic: busy phase, then a quiet-clear phase that can saturate.
    step(1'b1, 4'b0000, 1'b1, 2'd0, 1'b0);
    for (int n = 0; n < 3000; n++) begin
      bit r, c;
      if (n < 1000) begin
        r = ($urandom_range(0, 63) == 0);
        c = ($urandom_range(0, 7) == 0);
      end else begin
        r = ($urandom_range(0, 1023) == 0);
        c = ($urandom_range(0, 511) == 0);
      end
      step(r, 4'($urandom), ($urandom_range(0, 7) != 0), 2'($urandom), c);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
